uart_rx_loader: RTL and testbench

Serial receiver that sits directly upstream of the matrix memory and the UART transmit stage. It deserialises 10-bit frames from the rx line: start bit 0, 8 data bits LSB-first, stop bit 1. Each valid byte is written into the matrix RAM at a sequential address. After DEPTH words, it pulses done so the matrix operation can start; that logic later raises finish to the transmitter.

---
 rtl/uart_rx_loader_pkg.sv | 25 ++
 rtl/uart_rx_loader_if.sv | 18 +
 rtl/uart_rx_bit_timer.sv | 73 +++++++
 rtl/uart_rx_loader.sv | 156 +++++++++++++++
 tb/tb_uart_rx_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_loader_pkg.sv
// Shared definitions for the matrix-load UART receiver and its transmitter peer.
// Contents: receiver FSM state encoding, serial frame constants, default
// geometry of the matrix RAM, and a helper for the mid-bit sample offset.
package uart_rx_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

  localparam int MAT_DEPTH  = 1024;
  localparam int MAT_ADDR_W = 10;

  // Offset from the start-bit edge to the middle of a bit; 0 at one clock per bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_loader_if.sv
// RAM write bus from the receiver into the matrix memory.
//   wr_en   - one-cycle write strobe
//   wr_addr - write address (current word count)
//   wr_data - received byte, valid with wr_en
//   done    - pulses with the write to the last address of a load
// master: the receiver drives the bus; slave: the RAM / sequencer observes it.
interface uart_rx_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;

  modport master (output wr_en, wr_addr, wr_data, done);
  modport slave  (input  wr_en, wr_addr, wr_data, done);
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit timing for the UART receiver: a clock-per-bit down-counter and the
// data bit index.
//   clk, rst_n  - clock, asynchronous active-low reset
//   abort_i     - return counter and index to 0 (frame aborted)
//   start_i     - start bit seen: load the mid-bit offset, clear the index
//   run_i       - frame in progress, count down
//   step_i      - advance the bit index on each sample (data phase)
//   tick_o      - sample strobe: this cycle is a sample point
//   last_bit_o  - current index is the final data bit
module uart_rx_bit_timer
  import uart_rx_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort_i,
  input  logic start_i,
  input  logic run_i,
  input  logic step_i,
  output logic tick_o,
  output logic last_bit_o
);

  localparam int HALF  = half_bit(CLKS_PER_BIT);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  // With no half-bit offset the start sample itself confirms the start bit,
  // so the first wait is a full bit period straight to data bit 0.
  localparam logic [CNT_W-1:0] START_LOAD = (HALF == 0) ? BIT_RELOAD : CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign tick_o     = run_i && (cnt_q == '0);
  assign last_bit_o = (idx_q == LAST_IDX);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (abort_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (start_i) begin
      cnt_d = START_LOAD;
      idx_d = '0;
    end else if (tick_o) begin
      cnt_d = BIT_RELOAD;
      if (step_i) idx_d = idx_q + IDX_W'(1);
    end else if (run_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// UART receiver that loads the matrix RAM. Frames are start bit 0, DATA_W
// data bits LSB-first, stop bit 1. Each good byte is written at the next
// sequential address; done pulses with the DEPTH-th write, after which the
// address wraps to 0 and loading continues.
//   clk, rst_n - clock, asynchronous active-low reset
//   rx         - serial line, idle high
//   clear      - synchronous: word count to 0, abort frame, suppress a pending write
//   wr_bus     - RAM write bus (wr_en, wr_addr, wr_data, done), master side
//   frame_err  - one-cycle pulse when a frame ends with a bad stop bit
//   busy       - high while a frame is being received
// Build option RX_SYNC_EN: rx passes through a two-flop synchroniser (reset
// to idle-high); all sample points and the write latency move by 2 cycles.
module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = MAT_DEPTH,
  parameter int ADDR_W       = MAT_ADDR_W,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     clear,
  uart_rx_loader_if.master         wr_bus,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int                HALF      = half_bit(CLKS_PER_BIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], rx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  // rx is already synchronous to clk (internal loopback from the transmitter).
  assign rx_s = rx;
`endif

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              pend_q, pend_d;
  logic              ferr_q, ferr_d;

  logic tick, last_bit, timer_start, wr_fire, at_last;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort_i    (clear),
    .start_i    (timer_start),
    .run_i      (state_q != IDLE),
    .step_i     (state_q == DATA),
    .tick_o     (tick),
    .last_bit_o (last_bit)
  );

  // A good frame leaves a write pending for one cycle; clear in that cycle
  // cancels it, which is why the strobe is gated combinationally.
  assign wr_fire = pend_q && !clear;
  assign at_last = (count_q == LAST_ADDR);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    data_d      = data_q;
    pend_d      = 1'b0;
    ferr_d      = 1'b0;
    timer_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) begin
          timer_start = 1'b1;
          state_d     = (HALF == 0) ? DATA : START;
        end
      end
      START: begin
        // A start bit gone high by mid-bit is a glitch: drop it silently.
        if (tick) state_d = (rx_s == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (last_bit) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s == STOP_BIT) begin
            pend_d = 1'b1;
            data_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d     = IDLE;
      data_d      = data_q;
      pend_d      = 1'b0;
      ferr_d      = 1'b0;
      timer_start = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear)        count_d = '0;
    else if (wr_fire) count_d = at_last ? '0 : count_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      ferr_q  <= ferr_d;
    end
  end

  assign wr_bus.wr_en   = wr_fire;
  assign wr_bus.wr_addr = count_q;
  assign wr_bus.wr_data = data_q;
  assign wr_bus.done    = wr_fire && at_last;
  assign frame_err      = ferr_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: one instance at 1 clock per bit and one
// at 16 clocks per bit, sharing clock and reset. Inputs change on the falling
// edge; a monitor logs write strobes and frame errors 1 time unit after it.
// Cycle stamps are the posedge count seen at that falling edge, so a frame
// whose start bit is driven in cycle s writes in cycle s+1+HALF+9*CPB.
module tb_uart_rx_loader;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int   cyc;
    int   addr;
    int   data;
    logic done;
  } wr_t;

  logic clk, rst_n;
  logic rx1, rx16, clear1, clear16;
  logic ferr1, ferr16, busy1, busy16;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int done1  = 0;

  wr_t wq1[$];
  wr_t wq16[$];
  int  eq1[$];
  int  eq16[$];
  wr_t w1, w16;

  uart_rx_loader_if #(.ADDR_W(10), .DATA_W(8)) bus1 ();
  uart_rx_loader_if #(.ADDR_W(10), .DATA_W(8)) bus16 ();

  uart_rx_loader #(.DATA_W(8), .DEPTH(1024), .ADDR_W(10), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .clear(clear1),
    .wr_bus(bus1), .frame_err(ferr1), .busy(busy1)
  );

  uart_rx_loader #(.DATA_W(8), .DEPTH(1024), .ADDR_W(10), .CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx(rx16), .clear(clear16),
    .wr_bus(bus16), .frame_err(ferr16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (bus1.wr_en === 1'b1) begin
      w1.cyc = cyc; w1.addr = int'(bus1.wr_addr); w1.data = int'(bus1.wr_data); w1.done = bus1.done;
      wq1.push_back(w1);
    end
    if (bus1.done === 1'b1) done1++;
    if (ferr1 === 1'b1) eq1.push_back(cyc);
    if (bus16.wr_en === 1'b1) begin
      w16.cyc = cyc; w16.addr = int'(bus16.wr_addr); w16.data = int'(bus16.wr_data); w16.done = bus16.done;
      wq16.push_back(w16);
    end
    if (ferr16 === 1'b1) eq16.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare logged write number i of the chosen instance; a missing entry
  // shows up as -1 and fails every field.
  task automatic expect_wr(input int which, input string tag, input int i,
                           input int c, input int a, input int d, input logic dn);
    wr_t w;
    w.cyc = -1; w.addr = -1; w.data = -1; w.done = 1'bx;
    if (which == 1) begin
      if (i < wq1.size()) w = wq1[i];
    end else begin
      if (i < wq16.size()) w = wq16[i];
    end
    check({tag, "_cyc"},  w.cyc,  c);
    check({tag, "_addr"}, w.addr, a);
    check({tag, "_data"}, w.data, d);
    check({tag, "_done"}, 32'(w.done), 32'(dn));
  endtask

  task automatic drive(input int which, input logic v);
    @(negedge clk);
    if (which == 1) rx1 = v;
    else            rx16 = v;
  endtask

  task automatic idle(input int which, input int n);
    repeat (n) drive(which, 1'b1);
  endtask

  // Drive one frame; s returns the cycle in which the start bit was driven.
  task automatic send(input int which, input logic [7:0] b, input logic stop_b, output int s);
    logic [9:0] fr;
    int cpb;
    fr  = {stop_b, b, 1'b0};
    cpb = (which == 1) ? 1 : 16;
    s   = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < cpb; k++) begin
        drive(which, fr[i]);
        if (i == 0 && k == 0) s = cyc;
      end
    end
  endtask

  task automatic pulse_clear1();
    @(negedge clk); clear1 = 1'b1;
    @(negedge clk); clear1 = 1'b0;
  endtask

  initial begin
    int s, s0, bad;
    rst_n = 1'b0; rx1 = 1'b1; rx16 = 1'b1; clear1 = 1'b0; clear16 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en",  32'(bus1.wr_en),   0);
    check("rst_addr",   32'(bus1.wr_addr), 0);
    check("rst_data",   32'(bus1.wr_data), 0);
    check("rst_done",   32'(bus1.done),    0);
    check("rst_ferr",   32'(ferr1),        0);
    check("rst_busy",   32'(busy1),        0);
    check("rst_busy16", 32'(busy16),       0);
    @(negedge clk); rst_n = 1'b1;
    idle(1, 3);

    // Single frame 0xA5 from reset
    send(1, 8'hA5, 1'b1, s);
    idle(1, 4 + LAT);
    #2;
    check("a5_nwr", wq1.size(), 1);
    check("a5_nerr", eq1.size(), 0);
    expect_wr(1, "a5", 0, s + 10 + LAT, 0, 'hA5, 1'b0);

    // Back-to-back 0x00, 0xFF, 0x3C after a clear
    pulse_clear1();
    #2;
    check("clr_addr", 32'(bus1.wr_addr), 0);
    wq1.delete(); eq1.delete();
    send(1, 8'h00, 1'b1, s0);
    send(1, 8'hFF, 1'b1, s);
    send(1, 8'h3C, 1'b1, s);
    idle(1, 4 + LAT);
    #2;
    check("b2b_nwr", wq1.size(), 3);
    expect_wr(1, "b2b0", 0, s0 + 10 + LAT, 0, 'h00, 1'b0);
    expect_wr(1, "b2b1", 1, s0 + 20 + LAT, 1, 'hFF, 1'b0);
    expect_wr(1, "b2b2", 2, s0 + 30 + LAT, 2, 'h3C, 1'b0);

    // Bad stop bit, then a good frame
    pulse_clear1();
    wq1.delete(); eq1.delete();
    send(1, 8'h55, 1'b0, s0);
    idle(1, 3);
    send(1, 8'h12, 1'b1, s);
    idle(1, 4 + LAT);
    #2;
    check("ferr_n", eq1.size(), 1);
    check("ferr_cyc", (eq1.size() > 0) ? eq1[0] : -1, s0 + 10 + LAT);
    check("ferr_nwr", wq1.size(), 1);
    expect_wr(1, "after_err", 0, s + 10 + LAT, 0, 'h12, 1'b0);

    // Full load of 1024 words plus one to show the wrap
    pulse_clear1();
    wq1.delete(); eq1.delete(); done1 = 0;
    s0 = 0;
    for (int i = 0; i < 1025; i++) begin
      send(1, 8'(i % 256), 1'b1, s);
      if (i == 0) s0 = s;
    end
    idle(1, 4 + LAT);
    #2;
    check("load_nwr", wq1.size(), 1025);
    check("load_ndone", done1, 1);
    bad = 0;
    for (int i = 0; i < wq1.size() && i < 1025; i++) begin
      if (wq1[i].addr != i % 1024 || wq1[i].data != i % 256 ||
          wq1[i].done !== (i == 1023) || wq1[i].cyc != s0 + 10 * i + 10 + LAT)
        bad++;
    end
    check("load_seq_bad", bad, 0);
    expect_wr(1, "w1022", 1022, s0 + 10230 + LAT, 1022, 1022 % 256, 1'b0);
    expect_wr(1, "w1023", 1023, s0 + 10240 + LAT, 1023, 1023 % 256, 1'b1);
    expect_wr(1, "w1024", 1024, s0 + 10250 + LAT, 0,    0,          1'b0);

    // 16 clocks/bit: 4-cycle low glitch is rejected at the mid-bit check
    @(negedge clk); rx16 = 1'b0; s = cyc;
    repeat (1 + LAT) @(negedge clk);
    #1;
    check("glitch_busy_hi", 32'(busy16), 1);
    repeat (3 - LAT) @(negedge clk);
    rx16 = 1'b1;
    repeat (5 + LAT) @(negedge clk);
    #1;
    check("glitch_busy_lo", 32'(busy16), 0);
    idle(16, 5);
    #2;
    check("glitch_nwr", wq16.size(), 0);
    check("glitch_nerr", eq16.size(), 0);
    send(16, 8'h81, 1'b1, s);
    idle(16, 20);
    #2;
    check("x81_nwr", wq16.size(), 1);
    expect_wr(16, "x81", 0, s + 153 + LAT, 0, 'h81, 1'b0);

    // Reset after four data bits discards the partial byte
    wq1.delete(); eq1.delete();
    drive(1, 1'b0);
    drive(1, 1'b1); drive(1, 1'b1); drive(1, 1'b0); drive(1, 1'b0);
    @(negedge clk); rst_n = 1'b0; rx1 = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    idle(1, 2);
    send(1, 8'h7E, 1'b1, s);
    idle(1, 4 + LAT);
    #2;
    check("rstmid_nwr", wq1.size(), 1);
    check("rstmid_nerr", eq1.size(), 0);
    expect_wr(1, "rstmid", 0, s + 10 + LAT, 0, 'h7E, 1'b0);

    // Clear in the cycle of a pending write suppresses it
    wq1.delete(); eq1.delete();
    send(1, 8'h99, 1'b1, s);
    repeat (1 + LAT) drive(1, 1'b1);
    clear1 = 1'b1;
    @(negedge clk); clear1 = 1'b0;
    idle(1, 3);
    #2;
    check("clrwr_nwr", wq1.size(), 0);
    check("clrwr_addr", 32'(bus1.wr_addr), 0);
    check("clrwr_nerr", eq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
